io_target: RTL
==============

IO_TARGET -- requirements
Module: io_target

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of 32-bit storage words (power of 2, 2..256).
REQ-002 SHALL have parameter WAIT_STATES, default 2, wait cycles inserted before each response (0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset; reset asserts when reset=0.
REQ-005 SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  target accepts a request this cycle.
REQ-007 SHALL have port address  input  32  byte address of the request.
REQ-008 SHALL have port data_in  input  32  write data.
REQ-009 SHALL have port write_select  input  2  0 read, 1 write, 2 none, 3 illegal.
REQ-010 SHALL have port data_out  output  32  read data, valid with resp_valid.
REQ-011 SHALL have port resp_valid  output  1  one-cycle response strobe.
REQ-012 SHALL have port status  output  8  target status byte.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP; req_ready=1 only in IDLE.
REQ-014 SHALL accept a request on a rising edge where state=IDLE and req_valid=1, capturing address, data_in, write_select.
REQ-015 SHALL ignore write_select=2 requests: no capture, no state change, no response.
REQ-016 SHALL go IDLE->WAIT on acceptance when WAIT_STATES>0, else IDLE->RESP.
REQ-017 SHALL count WAIT_STATES cycles in WAIT, then go to RESP; the counter reloads on each acceptance.
REQ-018 SHALL hold resp_valid=1 for exactly one cycle in RESP, then return to IDLE; resp_valid is asserted WAIT_STATES+1 cycles after the accepting edge.
REQ-019 SHALL flag an error when address[1:0]!=0 (misaligned), address[31:2]>=DEPTH (range), or write_select=3 (illegal).
REQ-020 SHALL, for an error-free write, update word address[31:2] on the WAIT->RESP (or IDLE->RESP) edge; data_out=0 in RESP.
REQ-021 SHALL, for an error-free read, drive data_out=stored word in RESP, reflecting any write completed earlier.
REQ-022 SHALL, on error, perform no storage access and drive data_out=0 in RESP.
REQ-023 SHALL drive data_out=0 whenever resp_valid=0.
REQ-024 SHALL drive status[0]=busy (state!=IDLE).
REQ-025 SHALL drive status[1]=last_err, status[2]=misaligned, status[3]=range, status[4]=illegal; these update at RESP entry and hold until the next response.
REQ-026 SHALL drive status[7:5]=completed-response count modulo 8; it increments on every RESP, error or not, and wraps 7->0.
REQ-027 SHALL, when several error causes coincide, set every matching flag bit.

Reset
REQ-028 SHALL, while reset=0, force state=IDLE, req_ready=1, resp_valid=0, data_out=0, status=0, wait counter=0, all storage words=0.
REQ-029 SHALL abort any in-flight request on reset: no write, no response after reset release.
REQ-030 SHALL accept a request on the first rising edge after reset release.

Structure
REQ-031 SHALL place the FSM state encoding, the write_select constants (WS_READ, WS_WRITE, WS_NONE, WS_ILLEGAL), and the status bit positions in shared package io_pkg.
REQ-032 SHALL isolate storage in sub-module io_target_mem (DEPTH x 32, synchronous write, combinational read, async clear).

Verification
REQ-033 SHALL cover: reset, then write 0xDEADBEEF at 0x8 -> resp_valid exactly 3 cycles after accept, data_out=0, status=0x20.
REQ-034 SHALL cover: read 0x8 after REQ-033 -> data_out=0xDEADBEEF with resp_valid, status[7:5]=2.
REQ-035 SHALL cover: read 0x6 and write 0x40 (DEPTH=16) -> data_out=0 and no storage change; status[2]=1 for 0x6, status[3]=1 for 0x40.
REQ-036 SHALL cover: write_select=2 with req_valid -> no response, req_ready stays 1; write_select=3 -> status[4]=1.
REQ-037 SHALL cover: reset asserted during WAIT of a write to 0x4 -> after release, word 1 reads 0 and no resp_valid pulse occurs.
REQ-038 SHALL cover: 9 back-to-back requests with WAIT_STATES=0 -> one response every 2 cycles, status[7:5] wraps to 1.

Source files
------------

// File: rtl/io_pkg.sv
// Shared definitions for the io_target register-file target: FSM encoding,
// request opcodes, status byte layout and request classification.
package io_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } io_state_e;

    localparam logic [1:0] WS_READ    = 2'd0;
    localparam logic [1:0] WS_WRITE   = 2'd1;
    localparam logic [1:0] WS_NONE    = 2'd2;
    localparam logic [1:0] WS_ILLEGAL = 2'd3;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_ERR      = 1;
    localparam int STAT_MISALIGN = 2;
    localparam int STAT_RANGE    = 3;
    localparam int STAT_ILLEGAL  = 4;
    localparam int STAT_CNT_LSB  = 5;

    typedef struct packed {
        logic illegal;
        logic range_err;
        logic misalign;
    } err_flags_t;

    // Every matching cause is reported; causes are not mutually exclusive.
    function automatic err_flags_t classify(input logic [31:0] addr,
                                            input logic [1:0]  ws,
                                            input logic [31:0] depth);
        err_flags_t f;
        f.misalign  = (addr[1:0] != 2'b00);
        f.range_err = ({2'b00, addr[31:2]} >= depth);
        f.illegal   = (ws == WS_ILLEGAL);
        return f;
    endfunction

    function automatic logic any_err(input err_flags_t f);
        return f.illegal | f.range_err | f.misalign;
    endfunction

endpackage

// File: rtl/io_target_mem.sv
// Word storage for io_target: DEPTH x 32, synchronous write, combinational
// read, cleared asynchronously while reset is low.
module io_target_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] words [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
            logic [31:0] word_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    word_reg <= '0;
                end else if (we && (waddr == AW'(gi))) begin
                    word_reg <= wdata;
                end
            end

            assign words[gi] = word_reg;
        end
    endgenerate

    assign rdata = words[raddr];

endmodule

// File: rtl/io_target.sv
// Single-outstanding request target: accepts a read/write in IDLE, inserts
// WAIT_STATES wait cycles, then returns a one-cycle response with status.
module io_target
    import io_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    input  logic [1:0]  write_select,
    output logic [31:0] data_out,
    output logic        resp_valid,
    output logic [7:0]  status
);

    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES);
    localparam logic [31:0] DEPTH_W   = 32'(DEPTH);

    io_state_e   state_reg, state_next;
    logic [3:0]  wait_cnt_reg;
    logic [AW-1:0] idx_reg;
    logic [31:0] wdata_reg;
    logic [1:0]  ws_reg;
    err_flags_t  err_reg;
    logic [3:0]  flags_reg;
    logic [2:0]  resp_cnt_reg;

    logic          accept;
    logic          resp_enter;
    err_flags_t    in_err;
    err_flags_t    pend_err;
    logic [1:0]    pend_ws;
    logic [AW-1:0] pend_idx;
    logic [31:0]   pend_wdata;
    logic          mem_we;
    logic [31:0]   mem_rdata;

    assign in_err     = classify(address, write_select, DEPTH_W);
    assign accept     = (state_reg == IDLE) && req_valid && (write_select != WS_NONE);
    assign resp_enter = (state_next == RESP) && (state_reg != RESP);

    // With no wait states the response is entered on the accepting edge itself,
    // so the request fields come straight from the inputs rather than the capture.
    always_comb begin
        pend_ws    = ws_reg;
        pend_idx   = idx_reg;
        pend_wdata = wdata_reg;
        pend_err   = err_reg;
        if (state_reg == IDLE) begin
            pend_ws    = write_select;
            pend_idx   = address[AW+1:2];
            pend_wdata = data_in;
            pend_err   = in_err;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = (WAIT_STATES > 0) ? WAIT : RESP;
            WAIT: if (wait_cnt_reg <= 4'd1) state_next = RESP;
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= '0;
            idx_reg      <= '0;
            wdata_reg    <= '0;
            ws_reg       <= WS_READ;
            err_reg      <= '0;
            flags_reg    <= '0;
            resp_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                wait_cnt_reg <= WAIT_LOAD;
                idx_reg      <= address[AW+1:2];
                wdata_reg    <= data_in;
                ws_reg       <= write_select;
                err_reg      <= in_err;
            end else if (state_reg == WAIT) begin
                wait_cnt_reg <= wait_cnt_reg - 4'd1;
            end
            if (resp_enter) begin
                flags_reg    <= {pend_err.illegal, pend_err.range_err,
                                 pend_err.misalign, any_err(pend_err)};
                resp_cnt_reg <= resp_cnt_reg + 3'd1;
            end
        end
    end

    assign mem_we = resp_enter && (pend_ws == WS_WRITE) && !any_err(pend_err);

    io_target_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we),
        .waddr (pend_idx),
        .wdata (pend_wdata),
        .raddr (idx_reg),
        .rdata (mem_rdata)
    );

    assign req_ready  = (state_reg == IDLE);
    assign resp_valid = (state_reg == RESP);
    assign data_out   = (resp_valid && (ws_reg == WS_READ) && !any_err(err_reg))
                        ? mem_rdata : 32'd0;

    always_comb begin
        status                        = '0;
        status[STAT_BUSY]             = (state_reg != IDLE);
        status[STAT_ERR]              = flags_reg[0];
        status[STAT_MISALIGN]         = flags_reg[1];
        status[STAT_RANGE]            = flags_reg[2];
        status[STAT_ILLEGAL]          = flags_reg[3];
        status[STAT_CNT_LSB +: 3]     = resp_cnt_reg;
    end

endmodule
